ps2_mouse_ctrl: RTL

// - Sequences the PS/2 link for a mouse: runs the power-up handshake, then assembles 3-byte stream packets.
// - The handshake is reset (0xFF) -> ACK/BAT/ID, then enable-reporting (0xF4) -> ACK.
// - Sits between the PS/2 receiver FIFO (rd_en/rd_vld/rd_data) and the PS/2 transmitter (req/done).
// - Delivers decoded button/motion packets to the application.

---
 rtl/ps2_mouse_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse link sequencer: power-up handshake (0xFF, 0xF4) with retry/timeout,
// then assembly of 3-byte stream packets into button/motion outputs.
module ps2_mouse_ctrl #(
   parameter int TIMEOUT_CYC = 25_000_000,
   parameter int RETRY_MAX   = 3
) (
   input  logic       clk_sys,
   input  logic       rst_n,
   input  logic       rx_vld,
   input  logic [7:0] rx_data,
   output logic       rx_rd_en,
   output logic       tx_req,
   output logic [7:0] tx_data,
   input  logic       tx_done,
   output logic       init_done,
   output logic       init_err,
   output logic       pkt_vld,
   output logic [2:0] btn,
   output logic [8:0] dx,
   output logic [8:0] dy,
   output logic       ovf_x,
   output logic       ovf_y
);

   localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int RC_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [RC_W-1:0] RC_LAST = RC_W'(RETRY_MAX - 1);

   typedef enum logic [3:0] {
      S_SEND_RST, S_W_ACK1, S_W_BAT, S_W_ID, S_SEND_EN,
      S_W_ACK2, S_B0, S_B1, S_B2, S_ERR
   } state_t;

   state_t          state_q, state_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic [RC_W-1:0] fail_cnt_q, fail_cnt_d;
   logic            tx_req_q, tx_req_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            init_done_q, init_done_d;
   logic            init_err_q, init_err_d;
   logic [7:0]      b0_q, b0_d;
   logic [7:0]      b1_q, b1_d;
   logic            pkt_vld_q, pkt_vld_d;
   logic [2:0]      btn_q, btn_d;
   logic [8:0]      dx_q, dx_d;
   logic [8:0]      dy_q, dy_d;
   logic            ovf_x_q, ovf_x_d;
   logic            ovf_y_q, ovf_y_d;
   logic            pop;
   logic            timed_out;
   logic            fail;

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_SEND_RST;
         to_cnt_q    <= '0;
         fail_cnt_q  <= '0;
         tx_req_q    <= 1'b0;
         tx_data_q   <= 8'h00;
         init_done_q <= 1'b0;
         init_err_q  <= 1'b0;
         b0_q        <= 8'h00;
         b1_q        <= 8'h00;
         pkt_vld_q   <= 1'b0;
         btn_q       <= 3'b000;
         dx_q        <= 9'h000;
         dy_q        <= 9'h000;
         ovf_x_q     <= 1'b0;
         ovf_y_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         to_cnt_q    <= to_cnt_d;
         fail_cnt_q  <= fail_cnt_d;
         tx_req_q    <= tx_req_d;
         tx_data_q   <= tx_data_d;
         init_done_q <= init_done_d;
         init_err_q  <= init_err_d;
         b0_q        <= b0_d;
         b1_q        <= b1_d;
         pkt_vld_q   <= pkt_vld_d;
         btn_q       <= btn_d;
         dx_q        <= dx_d;
         dy_q        <= dy_d;
         ovf_x_q     <= ovf_x_d;
         ovf_y_q     <= ovf_y_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      fail_cnt_d  = fail_cnt_q;
      init_done_d = init_done_q;
      init_err_d  = init_err_q;
      b0_d        = b0_q;
      b1_d        = b1_q;
      pkt_vld_d   = 1'b0;
      btn_d       = btn_q;
      dx_d        = dx_q;
      dy_d        = dy_q;
      ovf_x_d     = ovf_x_q;
      ovf_y_d     = ovf_y_q;
      tx_data_d   = tx_data_q;
      fail        = 1'b0;
      pop         = rx_vld && (state_q != S_ERR);
      timed_out   = (to_cnt_q == TO_LAST);

      // A byte waiting in the FIFO wins over a timeout expiring in the same cycle.
      case (state_q)
         S_SEND_RST: if (tx_req_q && tx_done) state_d = S_W_ACK1;
         S_SEND_EN:  if (tx_req_q && tx_done) state_d = S_W_ACK2;
         S_W_ACK1, S_W_BAT, S_W_ID, S_W_ACK2: begin
            if (pop) begin
               if (rx_data == 8'hFE) begin
                  state_d = (state_q == S_W_ACK2) ? S_SEND_EN : S_SEND_RST;
               end else if (state_q == S_W_ACK1) begin
                  if (rx_data == 8'hFA) state_d = S_W_BAT;
                  else                  fail    = 1'b1;
               end else if (state_q == S_W_BAT) begin
                  if (rx_data == 8'hAA) state_d = S_W_ID;
                  else                  fail    = 1'b1;
               end else if (state_q == S_W_ID) begin
                  state_d = S_SEND_EN;
               end else if (rx_data == 8'hFA) begin
                  state_d     = S_B0;
                  init_done_d = 1'b1;
               end else begin
                  fail = 1'b1;
               end
            end else if (timed_out) begin
               fail = 1'b1;
            end
         end
         S_B0: begin
            if (pop && rx_data[3]) begin
               b0_d    = rx_data;
               state_d = S_B1;
            end
         end
         S_B1: begin
            if (pop) begin
               b1_d    = rx_data;
               state_d = S_B2;
            end else if (timed_out) begin
               state_d = S_B0;
            end
         end
         S_B2: begin
            if (pop) begin
               pkt_vld_d = 1'b1;
               btn_d     = b0_q[2:0];
               dx_d      = {b0_q[4], b1_q};
               dy_d      = {b0_q[5], rx_data};
               ovf_x_d   = b0_q[6];
               ovf_y_d   = b0_q[7];
               state_d   = S_B0;
            end else if (timed_out) begin
               state_d = S_B0;
            end
         end
         default: ;
      endcase

      if (fail) begin
         fail_cnt_d = fail_cnt_q + RC_W'(1);
         if (fail_cnt_q == RC_LAST) begin
            state_d    = S_ERR;
            init_err_d = 1'b1;
         end else begin
            state_d = S_SEND_RST;
         end
      end

      tx_req_d = (state_d == S_SEND_RST) || (state_d == S_SEND_EN);
      if (state_d == S_SEND_RST)     tx_data_d = 8'hFF;
      else if (state_d == S_SEND_EN) tx_data_d = 8'hF4;

      if (pop || (state_d != state_q)) to_cnt_d = '0;
      else if (!timed_out)             to_cnt_d = to_cnt_q + TO_W'(1);
      else                             to_cnt_d = to_cnt_q;
   end

   assign rx_rd_en  = rx_vld && (state_q != S_ERR);
   assign tx_req    = tx_req_q;
   assign tx_data   = tx_data_q;
   assign init_done = init_done_q;
   assign init_err  = init_err_q;
   assign pkt_vld   = pkt_vld_q;
   assign btn       = btn_q;
   assign dx        = dx_q;
   assign dy        = dy_q;
   assign ovf_x     = ovf_x_q;
   assign ovf_y     = ovf_y_q;

endmodule
